// File: rtl/text_console_if.sv
// Host-side port bundle of the text console: character stream, clear request,
// VRAM write port and cursor/busy status.
interface text_console_if;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        clear;
    logic        cea;
    logic [12:0] ada;
    logic [7:0]  din;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    modport master (
        output in_valid,
        output in_char,
        output clear,
        input  in_ready,
        input  cea,
        input  ada,
        input  din,
        input  cursor_col,
        input  cursor_row,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_char,
        input  clear,
        output in_ready,
        output cea,
        output ada,
        output din,
        output cursor_col,
        output cursor_row,
        output busy
    );
endinterface

// File: rtl/text_console.sv
// Character console: tracks the cursor and issues one VRAM write per cycle
// for glyphs, backspace blanks, row clears and full-screen clears.
module text_console #(
    parameter int         COLS  = 60,
    parameter int         ROWS  = 17,
    parameter logic [7:0] BLANK = 8'h20
) (
    input logic           PixelClk,
    input logic           nRST,
    text_console_if.slave bus
);
    localparam int TOTAL = COLS * ROWS;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ROWCLR
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic [5:0]  r_col;
    logic [5:0]  w_col;
    logic [4:0]  r_row;
    logic [4:0]  w_row;
    logic [12:0] r_ptr;
    logic [12:0] w_ptr;
    logic [12:0] r_last;
    logic [12:0] w_last;
    logic        r_cea;
    logic        w_cea;
    logic [12:0] r_ada;
    logic [12:0] w_ada;
    logic [7:0]  r_din;
    logic [7:0]  w_din;

    logic        w_idle;
    logic        w_accept;
    logic        w_print;
    logic        w_lf;
    logic        w_cr;
    logic        w_bs;
    logic        w_eol;
    logic [4:0]  w_nrow;
    logic [12:0] w_base;
    logic [12:0] w_nbase;

    function automatic logic [12:0] row_base(input logic [4:0] row);
        return 13'(row) * 13'(COLS);
    endfunction

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & ~bus.clear & bus.in_valid;

    assign w_print = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
    assign w_lf    = (bus.in_char == 8'h0A);
    assign w_cr    = (bus.in_char == 8'h0D);
    assign w_bs    = (bus.in_char == 8'h08);

    assign w_eol   = (r_col == 6'(COLS - 1));
    assign w_nrow  = (r_row == 5'(ROWS - 1)) ? 5'd0 : r_row + 5'd1;
    assign w_base  = row_base(r_row);
    assign w_nbase = row_base(w_nrow);

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_ptr   <= '0;
            r_last  <= '0;
            r_cea   <= 1'b0;
            r_ada   <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_state;
            r_col   <= w_col;
            r_row   <= w_row;
            r_ptr   <= w_ptr;
            r_last  <= w_last;
            r_cea   <= w_cea;
            r_ada   <= w_ada;
            r_din   <= w_din;
        end
    end

    always_comb begin
        w_state = r_state;
        w_col   = r_col;
        w_row   = r_row;
        w_ptr   = r_ptr;
        w_last  = r_last;
        w_cea   = 1'b0;
        w_ada   = r_ada;
        w_din   = r_din;

        unique case (r_state)
            IDLE: begin
                if (bus.clear) begin
                    w_state = CLEAR;
                    w_col   = '0;
                    w_row   = '0;
                    w_ptr   = '0;
                    w_last  = 13'(TOTAL - 1);
                end else if (w_accept) begin
                    unique case (1'b1)
                        w_print: begin
                            w_cea = 1'b1;
                            w_ada = w_base + 13'(r_col);
                            w_din = bus.in_char;
                            w_col = w_eol ? 6'd0 : r_col + 6'd1;
                        end
                        w_lf: w_col = '0;
                        w_cr: w_col = '0;
                        (w_bs && (r_col != 6'd0)): begin
                            w_col = r_col - 6'd1;
                            w_cea = 1'b1;
                            w_ada = w_base + 13'(r_col - 6'd1);
                            w_din = BLANK;
                        end
                        default: ;
                    endcase
                    // The glyph write (if any) goes out first; row clear follows.
                    if ((w_print && w_eol) || w_lf) begin
                        w_state = ROWCLR;
                        w_row   = w_nrow;
                        w_ptr   = w_nbase;
                        w_last  = w_nbase + 13'(COLS - 1);
                    end
                end
            end
            CLEAR, ROWCLR: begin
                w_cea = 1'b1;
                w_ada = r_ptr;
                w_din = BLANK;
                if (r_ptr == r_last) begin
                    w_state = IDLE;
                end else begin
                    w_ptr = r_ptr + 13'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.in_ready   = w_idle & ~bus.clear;
    assign bus.cea        = r_cea;
    assign bus.ada        = r_ada;
    assign bus.din        = r_din;
    assign bus.cursor_col = r_col;
    assign bus.cursor_row = r_row;
    assign bus.busy       = ~w_idle;
endmodule

// File: tb/tb_text_console.sv
// Randomized bench for text_console: a screen-level model predicts every
// VRAM write (cycle, address, data), the cursor, busy and in_ready.
module tb_text_console;
    localparam int COLS  = 60;
    localparam int ROWS  = 17;
    localparam int TOTAL = COLS * ROWS;
    localparam int PER   = 10;

    localparam int K_CHAR  = 0;
    localparam int K_CLR   = 1;
    localparam int K_CLRCH = 2;
    localparam int K_GAP   = 3;
    localparam int K_WAIT  = 4;

    typedef struct {
        longint slot;
        int     addr;
        int     data;
    } wr_t;

    typedef struct {
        int kind;
        int ch;
        int n;
    } op_t;

    logic PixelClk = 1'b0;
    logic nRST;

    text_console_if bus ();

    text_console #(
        .COLS (COLS),
        .ROWS (ROWS),
        .BLANK(8'h20)
    ) dut (
        .PixelClk(PixelClk),
        .nRST    (nRST),
        .bus     (bus)
    );

    always #(PER / 2) PixelClk = ~PixelClk;

    wr_t    exp_q[$];
    op_t    ops[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     m_col = 0;
    int     m_row = 0;
    longint m_busy_end = 0;
    bit     pending = 1'b0;
    int     pend_ch = 0;
    int     gap = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input longint slot, input int addr,
                                         input int data);
        return {slot[10:0], addr[12:0], data[7:0]};
    endfunction

    task automatic add(input int kind, input int ch, input int n);
        op_t o;
        o.kind = kind;
        o.ch   = ch;
        o.n    = n;
        ops.push_back(o);
    endtask

    task automatic push_wr(input longint slot, input int addr, input int data);
        wr_t w;
        w.slot = slot;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Screen model: row k's cells are k*COLS .. k*COLS+COLS-1.
    task automatic new_row(input longint k);
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++) push_wr(k + 1 + i, m_row * COLS + i, 'h20);
        m_busy_end = k + COLS;
    endtask

    task automatic model_char(input int c, input longint k);
        if (c >= 'h20 && c <= 'h7E) begin
            push_wr(k, m_row * COLS + m_col, c);
            if (m_col == COLS - 1) begin
                m_col = 0;
                new_row(k);
            end else begin
                m_col++;
            end
        end else if (c == 'h0A) begin
            m_col = 0;
            new_row(k);
        end else if (c == 'h0D) begin
            m_col = 0;
        end else if (c == 'h08 && m_col > 0) begin
            m_col--;
            push_wr(k, m_row * COLS + m_col, 'h20);
        end
    endtask

    task automatic model_clear(input longint k);
        m_col = 0;
        m_row = 0;
        for (int i = 0; i < TOTAL; i++) push_wr(k + 1 + i, i, 'h20);
        m_busy_end = k + TOTAL;
    endtask

    task automatic check_slot(input longint s);
        wr_t w;
        if (bus.cea) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexp", pack(s, int'(bus.ada), int'(bus.din)), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("wr", pack(s, int'(bus.ada), int'(bus.din)),
                    pack(w.slot, w.addr, w.data));
            end
            chk("ada_range", 32'(bus.ada < 13'(TOTAL)), 32'd1);
        end else if (exp_q.size() > 0 && exp_q[0].slot <= s) begin
            w = exp_q.pop_front();
            chk("wr_miss", 32'd0, pack(w.slot, w.addr, w.data));
        end
        chk("cursor", 32'({bus.cursor_row, bus.cursor_col}),
            32'({m_row[4:0], m_col[5:0]}));
        chk("busy", 32'(bus.busy), 32'(s < m_busy_end));
    endtask

    task automatic run_ops(input int budget);
        longint s;
        int     cyc;
        bit     clr;
        bit     pred;
        op_t    op;
        cyc = 0;
        while ((ops.size() > 0 || pending || gap > 0 || exp_q.size() > 0)
               && cyc < budget) begin
            @(negedge PixelClk);
            s = longint'($time) / PER;
            check_slot(s);
            clr = 1'b0;
            if (gap > 0) begin
                gap--;
            end else if (!pending && ops.size() > 0 &&
                         !(ops[0].kind == K_WAIT && s < m_busy_end)) begin
                op = ops.pop_front();
                case (op.kind)
                    K_CHAR: begin
                        pending = 1'b1;
                        pend_ch = op.ch;
                    end
                    K_CLR: clr = 1'b1;
                    K_CLRCH: begin
                        clr     = 1'b1;
                        pending = 1'b1;
                        pend_ch = op.ch;
                    end
                    K_GAP: gap = op.n;
                    default: ;
                endcase
            end
            bus.in_valid = pending;
            bus.in_char  = pending ? pend_ch[7:0] : 8'($urandom);
            bus.clear    = clr;
            #1;
            pred = (s >= m_busy_end) && !clr;
            chk("in_ready", 32'(bus.in_ready), 32'(pred));
            if (clr && s >= m_busy_end) begin
                model_clear(s + 1);
            end else if (pending && pred) begin
                model_char(pend_ch, s + 1);
                pending = 1'b0;
            end
            cyc++;
        end
        if (cyc >= budget) chk("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int  r;
        bit  hit;
        nRST         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.clear    = 1'b0;
        repeat (3) @(negedge PixelClk);
        chk("rst_cea", 32'(bus.cea), 32'd0);
        chk("rst_ada", 32'(bus.ada), 32'd0);
        chk("rst_din", 32'(bus.din), 32'd0);
        chk("rst_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        nRST = 1'b1;

        add(K_CHAR, 'h41, 0);
        add(K_CHAR, 'h42, 0);
        add(K_CHAR, 'h0D, 0);
        for (int i = 0; i < COLS; i++) add(K_CHAR, 'h41, 0);
        add(K_WAIT, 0, 0);
        add(K_CLRCH, 'h5A, 0);
        for (int i = 0; i < 16; i++) add(K_CHAR, 'h0A, 0);
        add(K_CHAR, 'h0D, 0);
        for (int i = 0; i < 5; i++) add(K_CHAR, 'h78, 0);
        add(K_CHAR, 'h0A, 0);
        add(K_CHAR, 'h0A, 0);
        add(K_CHAR, 'h0A, 0);
        add(K_CHAR, 'h61, 0);
        add(K_CHAR, 'h62, 0);
        add(K_CHAR, 'h63, 0);
        for (int i = 0; i < 4; i++) add(K_CHAR, 'h08, 0);
        add(K_CHAR, 'h0A, 0);
        add(K_CLR, 0, 0);
        add(K_CHAR, 'h7F, 0);
        add(K_CHAR, 'h00, 0);
        add(K_CHAR, 'h1B, 0);
        run_ops(6000);

        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 700)      add(K_CHAR, $urandom_range(32, 126), 0);
            else if (r < 760) add(K_CHAR, 'h0A, 0);
            else if (r < 800) add(K_CHAR, 'h0D, 0);
            else if (r < 900) add(K_CHAR, 'h08, 0);
            else if (r < 950) add(K_CHAR, $urandom_range(127, 255), 0);
            else if (r < 995) add(K_GAP, 0, $urandom_range(1, 4));
            else if (r < 997) add(K_CLR, 0, 0);
            else              add(K_CLRCH, $urandom_range(32, 126), 0);
        end
        run_ops(60000);

        @(negedge PixelClk);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b1;
        @(negedge PixelClk);
        bus.clear = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1200 && !hit; i++) begin
            if (bus.cea && bus.ada == 13'd500) hit = 1'b1;
            else @(negedge PixelClk);
        end
        chk("mid_clear_500", 32'(hit), 32'd1);
        nRST = 1'b0;
        #1;
        chk("arst_cea", 32'(bus.cea), 32'd0);
        chk("arst_ada", 32'(bus.ada), 32'd0);
        chk("arst_din", 32'(bus.din), 32'd0);
        chk("arst_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge PixelClk);
        nRST = 1'b1;
        m_col      = 0;
        m_row      = 0;
        m_busy_end = 0;
        pending    = 1'b0;
        gap        = 0;
        exp_q.delete();
        add(K_GAP, 0, 20);
        add(K_CHAR, 'h51, 0);
        add(K_CHAR, 'h52, 0);
        run_ops(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
